// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: nibble width, blank pattern
// and the active-low gfedcba hex segment table.
package seven_seg_pkg;

  localparam int NIBBLE_W = 4;
  localparam int SEG_W    = 7;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Entry [n] is the active-low gfedcba pattern for hex digit n.
  localparam logic [15:0][SEG_W-1:0] SEG_HEX = {
    7'h0E,  // F
    7'h06,  // E
    7'h21,  // d
    7'h46,  // C
    7'h03,  // b
    7'h08,  // A
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational hex nibble to active-low gfedcba segment decoder.
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [SEG_W-1:0]    seg
);

  always_comb begin
    seg = SEG_HEX[nibble];
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment scanner with double-buffered value and optional
// leading-zero blanking. Define SEVEN_SEG_DP_EN to add decimal-point support.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] value,
  input  logic                           load,
  input  logic                           blank_en,
`ifdef SEVEN_SEG_DP_EN
  input  logic [NUM_DIGITS-1:0]          dp_in,
`endif
  output logic [SEG_W-1:0]               seg_out,
  output logic [NUM_DIGITS-1:0]          an_out,
`ifdef SEVEN_SEG_DP_EN
  output logic                           dp_out,
`endif
  output logic                           digit_tick
);

  localparam int VAL_W = NIBBLE_W * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

  logic [PRE_W-1:0]      presc;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      next_idx;
  logic [VAL_W-1:0]      disp_val;
  logic [VAL_W-1:0]      pend_val;
  logic [VAL_W-1:0]      src_val;
  logic                  pend_valid;
  logic                  tick;
  logic                  frame_start;
  logic                  take_pend;
  logic                  upper_nz;
  logic                  blank;
  logic [NIBBLE_W-1:0]   nibble;
  logic [SEG_W-1:0]      dec_seg;
  logic [NUM_DIGITS-1:0] an_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (presc == PRE_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Gating with rst_n keeps the tick low during reset even when SCAN_DIV is 1.
  always_comb begin
    tick        = rst_n & (presc == PRE_LAST);
    frame_start = tick & (idx == LAST_IDX);
    take_pend   = frame_start & pend_valid;
    next_idx    = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    src_val     = take_pend ? pend_val : disp_val;
  end

  assign digit_tick = tick;

  // Digit selection and blanking look at the value that will be on display
  // after this edge, so a freshly applied value is already used for digit 0.
  always_comb begin
    nibble   = '0;
    upper_nz = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == next_idx) begin
        nibble = src_val[i*NIBBLE_W +: NIBBLE_W];
      end
      if ((i >= 32'(next_idx)) && (src_val[i*NIBBLE_W +: NIBBLE_W] != '0)) begin
        upper_nz = 1'b1;
      end
    end
    blank = blank_en & (next_idx != '0) & ~upper_nz;
  end

  always_comb begin
    an_next = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if ((IDX_W'(i) == next_idx) && !blank) begin
        an_next[i] = 1'b0;
      end
    end
  end

  seven_seg_decoder u_decoder (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= LAST_IDX;
      seg_out <= SEG_BLANK;
      an_out  <= '1;
    end else if (tick) begin
      idx     <= next_idx;
      seg_out <= blank ? SEG_BLANK : dec_seg;
      an_out  <= an_next;
    end
  end

  // A load on the frame-start edge lands in pending after the old pending
  // value has moved to display, so the valid flag stays set for next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_val   <= '0;
      pend_val   <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (take_pend) begin
        disp_val <= pend_val;
      end
      if (load) begin
        pend_val   <= value;
        pend_valid <= 1'b1;
      end else if (take_pend) begin
        pend_valid <= 1'b0;
      end
    end
  end

`ifdef SEVEN_SEG_DP_EN
  logic [NUM_DIGITS-1:0] pend_dp;
  logic [NUM_DIGITS-1:0] disp_dp;
  logic [NUM_DIGITS-1:0] src_dp;
  logic                  dp_bit;

  always_comb begin
    src_dp = take_pend ? pend_dp : disp_dp;
    dp_bit = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == next_idx) begin
        dp_bit = src_dp[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_dp <= '0;
      disp_dp <= '0;
    end else begin
      if (take_pend) begin
        disp_dp <= pend_dp;
      end
      if (load) begin
        pend_dp <= dp_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_out <= 1'b1;
    end else if (tick) begin
      dp_out <= blank | ~dp_bit;
    end
  end
`endif

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with NUM_DIGITS=4, SCAN_DIV=4.
module tb_seven_seg_scanner;

  localparam int ND = 4;
  localparam int SD = 4;

  logic          clk;
  logic          rst_n;
  logic [15:0]   value;
  logic          load;
  logic          blank_en;
  logic [6:0]    seg_out;
  logic [ND-1:0] an_out;
  logic          digit_tick;
`ifdef SEVEN_SEG_DP_EN
  logic [ND-1:0] dp_in;
  logic          dp_out;
`endif

  int errors;
  int checks;

  seven_seg_scanner #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .load       (load),
    .blank_en   (blank_en),
`ifdef SEVEN_SEG_DP_EN
    .dp_in      (dp_in),
    .dp_out     (dp_out),
`endif
    .seg_out    (seg_out),
    .an_out     (an_out),
    .digit_tick (digit_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        do_load;
    logic [15:0] val;
    logic        blank;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_an;
  } vec_t;

  localparam int NV = 31;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_disp(input string name, input logic [6:0] s, input logic [3:0] a);
    check({name, "_seg"}, 32'(seg_out), 32'(s));
    check({name, "_an"},  32'(an_out),  32'(a));
  endtask

  // Called #1 after a rising edge, right as rst_n is released.
  task automatic check_release(input string tag);
    check_disp({tag, "_rel0"}, 7'h7F, 4'hF);
    check({tag, "_tick0"}, 32'(digit_tick), 32'd0);
    cycles(1);
    check_disp({tag, "_rel1"}, 7'h7F, 4'hF);
    cycles(1);
    check_disp({tag, "_rel2"}, 7'h7F, 4'hF);
    check({tag, "_tick2"}, 32'(digit_tick), 32'd0);
    cycles(1);
    check_disp({tag, "_rel3"}, 7'h7F, 4'hF);
    check({tag, "_tick3"}, 32'(digit_tick), 32'd1);
    cycles(1);
    check_disp({tag, "_first"}, 7'h40, 4'hE);
    check({tag, "_tick4"}, 32'(digit_tick), 32'd0);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rst_n    = 1'b0;
    load     = 1'b0;
    value    = '0;
    blank_en = 1'b0;
`ifdef SEVEN_SEG_DP_EN
    dp_in    = '0;
`endif

    // Each vector spans one digit step; expected values are for the new digit.
    vecs[0]  = '{1'b1, 16'h1234, 1'b0, 7'h40, 4'hD};
    vecs[1]  = '{1'b0, 16'h0000, 1'b0, 7'h40, 4'hB};
    vecs[2]  = '{1'b0, 16'h0000, 1'b0, 7'h40, 4'h7};
    vecs[3]  = '{1'b0, 16'h0000, 1'b0, 7'h19, 4'hE};
    vecs[4]  = '{1'b0, 16'hFFFF, 1'b0, 7'h30, 4'hD};
    vecs[5]  = '{1'b0, 16'h0000, 1'b0, 7'h24, 4'hB};
    vecs[6]  = '{1'b0, 16'h0000, 1'b0, 7'h79, 4'h7};
    vecs[7]  = '{1'b0, 16'h0000, 1'b0, 7'h19, 4'hE};
    vecs[8]  = '{1'b0, 16'h0000, 1'b0, 7'h30, 4'hD};
    vecs[9]  = '{1'b0, 16'h0000, 1'b0, 7'h24, 4'hB};
    vecs[10] = '{1'b1, 16'hAAAA, 1'b0, 7'h79, 4'h7};
    vecs[11] = '{1'b0, 16'h0000, 1'b0, 7'h08, 4'hE};
    vecs[12] = '{1'b0, 16'h0000, 1'b0, 7'h08, 4'hD};
    vecs[13] = '{1'b0, 16'h0000, 1'b0, 7'h08, 4'hB};
    vecs[14] = '{1'b0, 16'h0000, 1'b0, 7'h08, 4'h7};
    vecs[15] = '{1'b1, 16'h0050, 1'b1, 7'h40, 4'hE};
    vecs[16] = '{1'b0, 16'h0000, 1'b1, 7'h12, 4'hD};
    vecs[17] = '{1'b0, 16'h0000, 1'b1, 7'h7F, 4'hF};
    vecs[18] = '{1'b0, 16'h0000, 1'b1, 7'h7F, 4'hF};
    vecs[19] = '{1'b1, 16'h0000, 1'b1, 7'h40, 4'hE};
    vecs[20] = '{1'b0, 16'h0000, 1'b1, 7'h7F, 4'hF};
    vecs[21] = '{1'b0, 16'h0000, 1'b1, 7'h7F, 4'hF};
    vecs[22] = '{1'b0, 16'h0000, 1'b1, 7'h7F, 4'hF};
    vecs[23] = '{1'b0, 16'h0000, 1'b0, 7'h40, 4'hE};
    vecs[24] = '{1'b0, 16'h0000, 1'b0, 7'h40, 4'hD};
    vecs[25] = '{1'b1, 16'h0105, 1'b1, 7'h7F, 4'hF};
    vecs[26] = '{1'b0, 16'h0000, 1'b1, 7'h7F, 4'hF};
    vecs[27] = '{1'b0, 16'h0000, 1'b1, 7'h12, 4'hE};
    vecs[28] = '{1'b0, 16'h0000, 1'b1, 7'h40, 4'hD};
    vecs[29] = '{1'b0, 16'h0000, 1'b1, 7'h79, 4'hB};
    vecs[30] = '{1'b0, 16'h0000, 1'b1, 7'h7F, 4'hF};

    @(posedge clk);
    #1;
    check_disp("reset", 7'h7F, 4'hF);
    check("reset_tick", 32'(digit_tick), 32'd0);
    cycles(1);
    rst_n = 1'b1;
    check_release("por");

    for (int i = 0; i < NV; i++) begin
      load     = vecs[i].do_load;
      value    = vecs[i].val;
      blank_en = vecs[i].blank;
      cycles(1);
      load = 1'b0;
      cycles(2);
      check($sformatf("vec%0d_tick", i), 32'(digit_tick), 32'd1);
      cycles(1);
      check_disp($sformatf("vec%0d", i), vecs[i].exp_seg, vecs[i].exp_an);
    end

    // Load on the frame-start edge while an older value is still pending.
    blank_en = 1'b0;
    value    = 16'h1111;
    load     = 1'b1;
    cycles(1);
    load = 1'b0;
    cycles(2);
    check("coinc_tick", 32'(digit_tick), 32'd1);
    value = 16'h2222;
    load  = 1'b1;
    cycles(1);
    load = 1'b0;
    check_disp("coinc_d0", 7'h79, 4'hE);
    cycles(4);
    check_disp("coinc_d1", 7'h79, 4'hD);
    cycles(8);
    check_disp("coinc_d3", 7'h79, 4'h7);
    cycles(4);
    check_disp("coinc_next", 7'h24, 4'hE);

    // Back-to-back loads: the last one wins at the next frame start.
    value = 16'h3333;
    load  = 1'b1;
    cycles(1);
    value = 16'h4444;
    cycles(1);
    load = 1'b0;
    cycles(2);
    check_disp("b2b_d1", 7'h24, 4'hD);
    cycles(8);
    check_disp("b2b_d3", 7'h24, 4'h7);
    cycles(4);
    check_disp("b2b_next", 7'h19, 4'hE);

    // Asynchronous reset mid-frame with a pending value that must be dropped.
    value = 16'h5555;
    load  = 1'b1;
    cycles(1);
    load  = 1'b0;
    rst_n = 1'b0;
    #1;
    check_disp("async_rst", 7'h7F, 4'hF);
    check("async_rst_tick", 32'(digit_tick), 32'd0);
    cycles(2);
    check_disp("rst_hold", 7'h7F, 4'hF);
    rst_n = 1'b1;
    check_release("rerel");
    cycles(12);
    check_disp("rerel_d3", 7'h40, 4'h7);
    cycles(4);
    check_disp("rerel_frame2", 7'h40, 4'hE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter SCAN_DIV, default 50000, clock cycles each digit is lit (legal >= 1).
REQ-003 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port value  input  4*NUM_DIGITS  hex nibbles; nibble 0 (LSBs) is digit 0 (rightmost).
REQ-006 SHALL have port load  input  1  one-cycle strobe capturing value into the pending register.
REQ-007 SHALL have port blank_en  input  1  leading-zero suppression enable, sampled per digit step.
REQ-008 SHALL have port seg_out  output  7  segments gfedcba, active-low (0 = lit).
REQ-009 SHALL have port an_out  output  NUM_DIGITS  digit enables, active-low, at most one bit low.
REQ-010 SHALL have port digit_tick  output  1  one-cycle pulse on every digit step.

Function
REQ-011 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; digit_tick SHALL be high exactly in the cycle the count equals SCAN_DIV-1.
REQ-012 On the edge ending a digit_tick cycle, the digit index SHALL advance by 1, wrapping NUM_DIGITS-1 -> 0; the wrap to 0 is "frame start".
REQ-013 seg_out and an_out SHALL be registered and SHALL reflect the new index on the same edge the index advances.
REQ-014 load SHALL write value into pending and set a pending-valid flag; the displayed register SHALL NOT change mid-frame.
REQ-015 At frame start with pending-valid set, the displayed register SHALL take pending, the flag SHALL clear, and digit 0 of that frame SHALL use the new value.
REQ-016 load coincident with frame start: the previous pending value SHALL be applied; the new value SHALL be held and applied at the next frame start.
REQ-017 Back-to-back loads within one frame: the last one SHALL win.
REQ-018 Nibble decode SHALL be 0-F standard hex (0=1000000, 1=1111001, 4=0011001, A=0001000, F=0001110).
REQ-019 With blank_en=1, a digit above the highest non-zero nibble SHALL show seg_out=7'h7F with its anode deasserted; digit 0 SHALL always be shown.
REQ-020 NUM_DIGITS=1 SHALL keep an_out=0 after the first tick and frame start on every tick.

Reset
REQ-021 Asserted rst_n SHALL immediately force seg_out=7'h7F, an_out=all 1, digit_tick=0, prescaler=0, index=NUM_DIGITS-1, displayed=0, pending=0, flag=0.
REQ-022 After release, outputs SHALL stay dark until the first digit_tick (SCAN_DIV cycles), which is a frame start.

Configuration
REQ-023 SEVEN_SEG_DP_EN defined: SHALL add input dp_in[NUM_DIGITS-1:0] (captured with value on load) and output dp_out (active-low, registered like seg_out, high when digit blanked).
REQ-024 SEVEN_SEG_DP_EN undefined: no dp_in/dp_out ports, no decimal-point storage.

Structure
REQ-025 Shared package seven_seg_pkg SHALL hold SEG_BLANK=7'h7F, NIBBLE_W=4 and the hex segment table constants.
REQ-026 Decode SHALL use one instance of sub-module seven_seg_decoder (4-bit hex in, 7-bit gfedcba active-low out).
REQ-027 Index width SHALL be $clog2(NUM_DIGITS), minimum 1.

Verification (NUM_DIGITS=4, SCAN_DIV=4)
REQ-028 Reset release -> seg_out=7F, an_out=F for 4 cycles; after first tick an_out=1110, seg_out=1000000.
REQ-029 load 16'h1234 before frame start, blank_en=0 -> an 1110/1101/1011/0111 with seg 0011001/0110000/0100100/1111001, each 4 cycles, repeating.
REQ-030 blank_en=1, value 16'h0050 -> digit0 1000000, digit1 0010010, digits 2-3 seg 7F with anode high; value 0 -> only digit0 shows 1000000.
REQ-031 Display 1234, load 16'hAAAA while digit 2 lit -> digits 2,3 still 2,1; next frame all digits 0001000.
REQ-032 load coincident with frame start and pending-valid set -> old pending shown this frame, new value next frame.
REQ-033 rst_n low mid-frame -> outputs dark in same cycle (asynchronous); after release behaviour matches REQ-028.
